oled_char_serializer: RTL and testbench
=======================================

// Module: oled_char_serializer
// PURPOSE
//  - Consumes ASCII character codes and turns each into 8 column bytes for the ZynqOLED SPI byte sender.
//  - Drives the address of the 128-entry 64-bit glyph ROM and registers the returned glyph.
//  - Shifts the glyph out as a byte stream under a valid/ready handshake, MSB byte first.
//  - Tracks the character column so it can flag end-of-line for page addressing downstream.
// PARAMETERS
//  CHARS_PER_LINE  16  characters per OLED page row; the column counter wraps at this value
//  BAD_GLYPH       127 ROM address substituted for any code >= 128 (checkerboard glyph)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  char_valid   in   1   char_code/char_invert valid
//  char_ready   out  1   block can accept a character
//  char_code    in   8   ASCII code
//  char_invert  in   1   1 = emit bitwise-inverted bytes (cursor/highlight)
//  home         in   1   single-cycle pulse: character column counter := 0
//  rom_addr     out  8   glyph ROM address (registered)
//  rom_data     in   64  glyph ROM data, combinational from rom_addr
//  byte_valid   out  1   byte_data valid
//  byte_ready   in   1   downstream accepts byte_data
//  byte_data    out  8   column byte, bit0 = top pixel
//  byte_last    out  1   last (8th) byte of the current character
//  byte_eol     out  1   byte_last of the character in column CHARS_PER_LINE-1
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state IDLE, char_ready=1, byte_valid=0, byte_data=0, byte_last=0,
//    byte_eol=0, rom_addr=0, busy=0, shift register=0, byte index=0, column=0. A byte in flight is dropped.
//  - FSM IDLE -> LOAD -> SEND -> IDLE; char_ready = (state==IDLE).
//  - IDLE: on char_valid&char_ready (cycle T): rom_addr <= code[7] ? BAD_GLYPH : code; latch invert and
//    eol_flag = (column == CHARS_PER_LINE-1); go to LOAD.
//  - LOAD (T+1): shift register <= invert ? ~rom_data : rom_data; byte index <= 0; go to SEND.
//  - SEND: byte_valid=1 from T+2. byte_data = shift[63:56]. On byte_valid&byte_ready: shift <<= 8 and
//    index++. byte_data/last/eol are held stable while byte_valid=1 and byte_ready=0.
//  - byte_last=1 when index==7; byte_eol = byte_last & eol_flag.
//  - On handshake of byte index 7: go to IDLE (char_ready=1 next cycle). Column += 1, wrapping
//    CHARS_PER_LINE-1 -> 0.
//  - Minimum cost per character is 10 cycles (accept, load, 8 bytes); no back-to-back overlap.
//  - home: column := 0 in any state. If it coincides with the final-byte handshake, home wins (column 0).
//    If it coincides with an acceptance in IDLE, that character is treated as column 0 (eol_flag computed from 0).
//  - The column counter width is $clog2(CHARS_PER_LINE); CHARS_PER_LINE must be >= 2.
//  - char_code/char_invert are sampled only at acceptance; changes afterward are ignored.
// STRUCTURE
//  - The shared package holds the state enum (IDLE, LOAD, SEND), GLYPH_BYTES=8, and GLYPH_W=64.
//  - Single module; the 64-bit shift register plus byte index stays inline.
//  - The ROM is instantiated by the parent and connected through rom_addr/rom_data.
// TESTING
//  1. 'A' (0x41), byte_ready=1: bytes 40 7c 4a 09 4a 7c 40 00, byte_last on the 8th byte,
//     first byte_valid at T+2, char_ready high again at T+10.
//  2. '1' (0x31) with char_invert=1: bytes ff ff be 80 bf ff ff ff.
//  3. Code 0xC1: rom_addr=127; bytes aa 55 aa 55 aa 55 aa 55.
//  4. 16 characters back-to-back: byte_eol asserted only on the last byte of the 16th character;
//     the 17th character is column 0 with no eol. Add home mid-line and check the reset to column 0.
//  5. byte_ready toggled randomly on 'C': byte_data stable while stalled; output equals
//     1c 22 41 41 41 41 22 00 with no drop or duplicate.
//  6. rst_n low during byte 3 of 'B': outputs go to reset values immediately; the next char '!'
//     emits 00 00 00 5f 00 00 00 00 with byte_eol=0.

Source files
------------

// File: rtl/oled_char_serializer_pkg.sv
// Shared types and constants for the OLED character serializer.
package oled_char_serializer_pkg;

  localparam int GLYPH_BYTES = 8;
  localparam int GLYPH_W     = 64;
  localparam int IDX_W       = $clog2(GLYPH_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

endpackage

// File: rtl/oled_char_serializer.sv
// Turns ASCII codes into 8 glyph column bytes (MSB byte first) for the OLED SPI byte sender,
// tracking the character column to flag end-of-line.
module oled_char_serializer
  import oled_char_serializer_pkg::*;
#(
  parameter int CHARS_PER_LINE = 16,
  parameter int BAD_GLYPH      = 127
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               char_valid,
  output logic               char_ready,
  input  logic [7:0]         char_code,
  input  logic               char_invert,
  input  logic               home,
  output logic [7:0]         rom_addr,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic [7:0]         byte_data,
  output logic               byte_last,
  output logic               byte_eol,
  output logic               busy
);

  localparam int               COL_W    = $clog2(CHARS_PER_LINE);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHARS_PER_LINE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GLYPH_BYTES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_rom_addr;
  logic                 r_invert;
  logic                 r_eol_flag;
  logic [GLYPH_W-1:0]   r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic [COL_W-1:0]     r_col;
  logic                 w_accept;
  logic                 w_byte_fire;
  logic                 w_last_fire;

  assign w_accept    = char_valid && (r_state == IDLE);
  assign w_byte_fire = (r_state == SEND) && byte_ready;
  assign w_last_fire = w_byte_fire && (r_idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SEND;
      SEND:    if (w_last_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_invert   <= 1'b0;
      r_eol_flag <= 1'b0;
      r_shift    <= '0;
      r_idx      <= '0;
    end else begin
      if (w_accept) begin
        r_rom_addr <= char_code[7] ? 8'(BAD_GLYPH) : char_code;
        r_invert   <= char_invert;
        // A simultaneous home places this character in column 0, which is never the last column.
        r_eol_flag <= !home && (r_col == LAST_COL);
      end
      if (r_state == LOAD) begin
        r_shift <= r_invert ? ~rom_data : rom_data;
        r_idx   <= '0;
      end else if (w_byte_fire) begin
        r_shift <= {r_shift[GLYPH_W-9:0], 8'h00};
        r_idx   <= r_idx + IDX_W'(1);
      end
    end
  end

  // home takes priority over the end-of-character advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_col <= '0;
    else if (home)        r_col <= '0;
    else if (w_last_fire) r_col <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
  end

  assign char_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign rom_addr   = r_rom_addr;
  assign byte_valid = (r_state == SEND);
  assign byte_data  = r_shift[GLYPH_W-1 -: 8];
  assign byte_last  = byte_valid && (r_idx == LAST_IDX);
  assign byte_eol   = byte_last && r_eol_flag;

endmodule

// File: tb/tb_oled_char_serializer.sv
// Directed bench for oled_char_serializer with a small glyph ROM model.
module tb_oled_char_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_valid = 1'b0;
  logic        char_invert = 1'b0;
  logic        home = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  char_code = 8'h00;
  logic        char_ready, byte_valid, byte_last, byte_eol, busy;
  logic [7:0]  rom_addr, byte_data;
  logic [63:0] rom_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  code;
    logic        inv;
    logic [7:0]  addr;
    logic [63:0] bytes;
    logic        eol;
    bit          stall;
  } vec_t;

  vec_t vecs[4];

  oled_char_serializer #(.CHARS_PER_LINE(16), .BAD_GLYPH(127)) dut (
    .clk(clk), .rst_n(rst_n),
    .char_valid(char_valid), .char_ready(char_ready),
    .char_code(char_code), .char_invert(char_invert), .home(home),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .byte_eol(byte_eol), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] glyph(input logic [7:0] a);
    case (a)
      8'h21:   return 64'h0000005f00000000;
      8'h31:   return 64'h0000417f40000000;
      8'h41:   return 64'h407c4a094a7c4000;
      8'h42:   return 64'h7f49494936000000;
      8'h43:   return 64'h1c22414141412200;
      8'h7f:   return 64'haa55aa55aa55aa55;
      default: return {8{a}};
    endcase
  endfunction

  assign rom_data = glyph(rom_addr);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // home_mode: 0 none, 1 with acceptance, 2 with the final byte handshake.
  task automatic run_char(input string name, input logic [7:0] code, input logic inv,
                          input logic [7:0] addr, input logic [63:0] bytes, input logic eol,
                          input bit stall, input int home_mode);
    int cyc;
    int nb;
    bit have_prev;
    bit prev_taken;
    logic [7:0] prev_data;
    logic prev_last;
    cyc = 0;
    @(negedge clk);
    while (char_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " char_ready idle"}, char_ready, 1);
    char_valid  = 1'b1;
    char_code   = code;
    char_invert = inv;
    home        = (home_mode == 1);
    @(negedge clk);
    char_valid  = 1'b0;
    home        = 1'b0;
    char_code   = ~code;
    char_invert = ~inv;
    check({name, " rom_addr"}, rom_addr, addr);
    check({name, " load valid"}, byte_valid, 0);
    check({name, " load busy"}, busy, 1);
    check({name, " load ready"}, char_ready, 0);
    @(negedge clk);
    check({name, " first valid T+2"}, byte_valid, 1);
    nb = 0;
    cyc = 0;
    have_prev = 0;
    prev_taken = 0;
    prev_data = '0;
    prev_last = 1'b0;
    while (nb < 8 && cyc < 200) begin
      byte_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (have_prev && !prev_taken) begin
        check($sformatf("%s stall data b%0d", name, nb), byte_data, prev_data);
        check($sformatf("%s stall last b%0d", name, nb), byte_last, prev_last);
      end
      check($sformatf("%s valid b%0d", name, nb), byte_valid, 1);
      if (byte_ready) begin
        check($sformatf("%s data b%0d", name, nb), byte_data, bytes[63-8*nb -: 8]);
        check($sformatf("%s last b%0d", name, nb), byte_last, (nb == 7));
        check($sformatf("%s eol b%0d", name, nb), byte_eol, (eol && nb == 7));
        if (home_mode == 2 && nb == 7) home = 1'b1;
        nb++;
      end
      prev_data  = byte_data;
      prev_last  = byte_last;
      prev_taken = byte_ready;
      have_prev  = 1;
      @(negedge clk);
      home = 1'b0;
      cyc++;
    end
    check({name, " byte count"}, nb, 8);
    check({name, " ready after"}, char_ready, 1);
    check({name, " valid after"}, byte_valid, 0);
    if (!stall) check({name, " cycles to ready T+10"}, cyc, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{code: 8'h41, inv: 1'b0, addr: 8'h41, bytes: 64'h407c4a094a7c4000, eol: 1'b0, stall: 1'b0};
    vecs[1] = '{code: 8'h31, inv: 1'b1, addr: 8'h31, bytes: 64'hffffbe80bfffffff, eol: 1'b0, stall: 1'b0};
    vecs[2] = '{code: 8'hc1, inv: 1'b0, addr: 8'h7f, bytes: 64'haa55aa55aa55aa55, eol: 1'b0, stall: 1'b0};
    vecs[3] = '{code: 8'h43, inv: 1'b0, addr: 8'h43, bytes: 64'h1c22414141412200, eol: 1'b0, stall: 1'b1};

    repeat (2) @(negedge clk);
    check("reset char_ready", char_ready, 1);
    check("reset byte_valid", byte_valid, 0);
    check("reset byte_data", byte_data, 0);
    check("reset byte_last", byte_last, 0);
    check("reset byte_eol", byte_eol, 0);
    check("reset rom_addr", rom_addr, 0);
    check("reset busy", busy, 0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_char($sformatf("vec%0d", i), vecs[i].code, vecs[i].inv, vecs[i].addr,
               vecs[i].bytes, vecs[i].eol, vecs[i].stall, 0);

    // Standalone home in IDLE, then a full line plus one.
    @(negedge clk); home = 1'b1;
    @(negedge clk); home = 1'b0;
    for (int i = 0; i < 17; i++)
      run_char($sformatf("line c%0d", i), 8'h50 + 8'(i), 1'b0, 8'h50 + 8'(i),
               glyph(8'h50 + 8'(i)), (i == 15), 1'b0, 0);

    // Column is now 1; home with the acceptance of the 4th character restarts the line there.
    for (int i = 0; i < 19; i++)
      run_char($sformatf("homeacc c%0d", i), 8'h20 + 8'(i), 1'b0, 8'h20 + 8'(i),
               glyph(8'h20 + 8'(i)), (i == 18), 1'b0, (i == 3) ? 1 : 0);

    // home on the final handshake of the 5th character wins over the column advance.
    for (int i = 0; i < 21; i++)
      run_char($sformatf("homelast c%0d", i), 8'h60 + 8'(i), 1'b0, 8'h60 + 8'(i),
               glyph(8'h60 + 8'(i)), (i == 20), 1'b0, (i == 4) ? 2 : 0);

    // Asynchronous reset while byte 3 of 'B' is on the output.
    @(negedge clk);
    check("rst B idle", char_ready, 1);
    char_valid = 1'b1;
    char_code  = 8'h42;
    char_invert = 1'b0;
    byte_ready = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst B byte3", byte_data, 8'h49);
    rst_n = 1'b0;
    #1;
    check("async char_ready", char_ready, 1);
    check("async byte_valid", byte_valid, 0);
    check("async byte_data", byte_data, 0);
    check("async byte_last", byte_last, 0);
    check("async byte_eol", byte_eol, 0);
    check("async rom_addr", rom_addr, 0);
    check("async busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_char("bang", 8'h21, 1'b0, 8'h21, 64'h0000005f00000000, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
